capture_frame_buffer: RTL



---
 rtl/capture_frame_buffer_pkg.sv | 13 +
 rtl/capture_frame_buffer_sync_fifo_fwft.sv | 57 +++++
 rtl/capture_frame_buffer.sv | 90 +++++++++
 3 files changed

// File: rtl/capture_frame_buffer_pkg.sv
// Shared widths and the stored entry layout for the capture frame buffer.
package capture_frame_buffer_pkg;

   localparam int unsigned CFB_DW    = 16;
   localparam int unsigned CFB_DEPTH = 16;
   localparam int unsigned CFB_FCW   = 8;

   typedef struct packed {
      logic              last;
      logic [CFB_DW-1:0] data;
   } entry_t;

endpackage

// File: rtl/capture_frame_buffer_sync_fifo_fwft.sv
// First-word-fall-through synchronous FIFO: storage, pointers and fill level.
module sync_fifo_fwft #(
   parameter int unsigned W     = 17,
   parameter int unsigned DEPTH = 16,
   parameter int unsigned AW    = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic          rd_en,
   input  logic [W-1:0]  wdata,
   output logic [W-1:0]  rdata,
   output logic [AW:0]   level,
   output logic          full,
   output logic          valid,
   output logic          pop
);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   level_q, level_d;

   always_comb begin
      valid    = (level_q != '0);
      full     = (level_q == (AW+1)'(DEPTH));
      pop      = rd_en && valid;
      wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
      level_d  = level_q;
      case ({push, pop})
         2'b10:   level_d = level_q + (AW+1)'(1);
         2'b01:   level_d = level_q - (AW+1)'(1);
         default: level_d = level_q;
      endcase
      // Empty FIFO presents zeros so stale RAM never leaks onto the outputs.
      rdata = valid ? mem_q[rd_ptr_q] : '0;
      level = level_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && push) mem_q[wr_ptr_q] <= wdata;
   end

endmodule

// File: rtl/capture_frame_buffer.sv
// Captures each WREN-high run as a frame, tags its last word, and buffers it for FWFT readout.
module capture_frame_buffer
   import capture_frame_buffer_pkg::*;
#(
   parameter int unsigned DW    = CFB_DW,
   parameter int unsigned DEPTH = CFB_DEPTH,
   parameter int unsigned AW    = 4,
   parameter int unsigned FCW   = CFB_FCW
) (
   input  logic           CLK,
   input  logic           RST,
   input  logic [DW-1:0]  DBUS,
   input  logic           WREN,
   input  logic           RD_EN,
   input  logic           CLR_OVF,
   output logic [DW-1:0]  DOUT,
   output logic           DLAST,
   output logic           DVALID,
   output logic           FULL,
   output logic [AW:0]    LEVEL,
   output logic           OVERFLOW,
   output logic [FCW-1:0] FRAME_CNT
);

   logic [DW-1:0]  hold_data_q, hold_data_d;
   logic           hold_v_q, hold_v_d;
   logic           ovf_q, ovf_d;
   logic [FCW-1:0] fcnt_q, fcnt_d;

   entry_t wr_entry, rd_entry;
   logic   push, accept, drop, pop, inc, dec;

   sync_fifo_fwft #(
      .W     ($bits(entry_t)),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_fifo (
      .clk   (CLK),
      .rst   (RST),
      .push  (accept),
      .rd_en (RD_EN),
      .wdata (wr_entry),
      .rdata (rd_entry),
      .level (LEVEL),
      .full  (FULL),
      .valid (DVALID),
      .pop   (pop)
   );

   always_comb begin
      // The held word is last exactly when the window has just closed.
      push          = hold_v_q;
      wr_entry.last = !WREN;
      wr_entry.data = hold_data_q;
      accept        = push && (!FULL || pop);
      drop          = push && !accept;
      hold_v_d      = WREN;
      hold_data_d   = WREN ? DBUS : hold_data_q;

      ovf_d = ovf_q;
      if (drop)         ovf_d = 1'b1;
      else if (CLR_OVF) ovf_d = 1'b0;

      inc    = accept && wr_entry.last;
      dec    = pop && rd_entry.last;
      fcnt_d = fcnt_q;
      if (inc && !dec && fcnt_q != '1) fcnt_d = fcnt_q + FCW'(1);
      else if (dec && !inc)            fcnt_d = fcnt_q - FCW'(1);

      DOUT      = rd_entry.data;
      DLAST     = rd_entry.last;
      OVERFLOW  = ovf_q;
      FRAME_CNT = fcnt_q;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         hold_data_q <= '0;
         hold_v_q    <= 1'b0;
         ovf_q       <= 1'b0;
         fcnt_q      <= '0;
      end else begin
         hold_data_q <= hold_data_d;
         hold_v_q    <= hold_v_d;
         ovf_q       <= ovf_d;
         fcnt_q      <= fcnt_d;
      end
   end

endmodule
